atm_main: RTL and testbench

ATM_MAIN -- requirements
Module: atm_main

---
 rtl/atm_main.sv | 240 ++++++++++++++++++++++++
 tb/tb_atm_main.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/atm_main.sv
// atm_main -- single-session ATM controller over a fixed 4-account table.
//
// Purpose:
//   Accepts a card, authenticates its PIN, then runs deposit / withdraw /
//   balance-enquiry / exit transactions against per-account 16-bit balance
//   registers. The balances persist across sessions and are reloaded only
//   by reset.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   start        in   session enable; low returns to IDLE from any state
//   cardnumber   in   [31:0] inserted card number
//   pin          in   [19:0] entered PIN, 0 = no entry
//   amount       in   [15:0] transaction amount
//   transaction  in   [2:0]  1 deposit, 2 withdraw, 3 enquiry, 4 exit
//   balance      out  [15:0] balance of the accepted account, else 0
//   state        out  [2:0]  IDLE=0 CARD=1 PIN=2 MENU=3 LOCKED=4
//   card_ok      out  card accepted
//   auth_ok      out  PIN accepted
//   locked       out  card locked
//   txn_done     out  one-cycle completion pulse
//   txn_err      out  one-cycle rejection pulse
//
// Configuration:
//   ATM_LOCKOUT_EN  when defined, the third wrong PIN attempt locks the
//                   account until reset and enters LOCKED. When undefined,
//                   attempts are unlimited and LOCKED is unreachable.

module atm_main (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] cardnumber,
  input  logic [19:0] pin,
  input  logic [15:0] amount,
  input  logic [2:0]  transaction,
  output logic [15:0] balance,
  output logic [2:0]  state,
  output logic        card_ok,
  output logic        auth_ok,
  output logic        locked,
  output logic        txn_done,
  output logic        txn_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CARD   = 3'd1,
    S_PIN    = 3'd2,
    S_MENU   = 3'd3,
    S_LOCKED = 3'd4
  } state_t;

`ifdef ATM_LOCKOUT_EN
  localparam bit LOCKOUT = 1'b1;
`else
  localparam bit LOCKOUT = 1'b0;
`endif

  // Account table, entry 0 in the least significant slot.
  localparam logic [3:0][31:0] CARD_TAB = {32'd44445555, 32'd33334444, 32'd22223333, 32'd11112222};
  localparam logic [3:0][19:0] PIN_TAB  = {20'd9999, 20'd4321, 20'd1234, 20'd5432};
  localparam logic [3:0][15:0] BAL_INIT = {16'd0, 16'd500, 16'd2500, 16'd1000};

  state_t            state_reg, state_next;
  logic [1:0]        idx_reg, idx_next;
  logic [1:0]        attempts_reg, attempts_next;
  logic [3:0]        lock_reg, lock_next;
  logic [3:0][15:0]  bal_reg, bal_next;
  logic              card_ok_reg, card_ok_next;
  logic              auth_ok_reg, auth_ok_next;
  logic              locked_reg, locked_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic [19:0]       pin_prev_reg;
  logic [2:0]        txn_prev_reg;

  logic [3:0]        card_hit;
  logic [1:0]        hit_idx;
  logic [15:0]       cur_bal;
  logic [16:0]       sum;
  logic              pin_attempt;
  logic              txn_go;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_match
      assign card_hit[gi] = (cardnumber == CARD_TAB[gi]);
    end
  endgenerate

  // Table card numbers are distinct, so at most one hit bit is set.
  always_comb begin
    hit_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (card_hit[i]) hit_idx = i[1:0];
    end
  end

  assign cur_bal = bal_reg[idx_reg];
  assign sum     = {1'b0, cur_bal} + {1'b0, amount};
  // Edge-style detection: a held value is one attempt / one transaction.
  assign pin_attempt = (pin != '0) && (pin != pin_prev_reg);
  assign txn_go      = (transaction inside {[3'd1:3'd4]}) && (transaction != txn_prev_reg);

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    attempts_next = attempts_reg;
    lock_next     = lock_reg;
    bal_next      = bal_reg;
    card_ok_next  = card_ok_reg;
    auth_ok_next  = auth_ok_reg;
    locked_next   = locked_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;

    if (!start) begin
      state_next    = S_IDLE;
      card_ok_next  = 1'b0;
      auth_ok_next  = 1'b0;
      locked_next   = 1'b0;
      attempts_next = 2'd0;
    end else begin
      case (state_reg)
        S_IDLE: state_next = S_CARD;

        S_CARD: begin
          locked_next = 1'b0;
          if (|card_hit) begin
            if (lock_reg[hit_idx]) begin
              locked_next = 1'b1;
            end else begin
              state_next    = S_PIN;
              card_ok_next  = 1'b1;
              idx_next      = hit_idx;
              attempts_next = 2'd0;
            end
          end
        end

        S_PIN: begin
          if (pin_attempt) begin
            if (pin == PIN_TAB[idx_reg]) begin
              state_next    = S_MENU;
              auth_ok_next  = 1'b1;
              attempts_next = 2'd0;
            end else begin
              err_next = 1'b1;
              if (LOCKOUT && attempts_reg == 2'd2) begin
                // Third consecutive miss: lock the account for good.
                lock_next[idx_reg] = 1'b1;
                state_next         = S_LOCKED;
                locked_next        = 1'b1;
                card_ok_next       = 1'b0;
                attempts_next      = 2'd0;
              end else if (attempts_reg != 2'd3) begin
                attempts_next = attempts_reg + 2'd1;
              end
            end
          end
        end

        S_MENU: begin
          if (txn_go) begin
            case (transaction)
              3'd1: begin
                if (sum[16]) begin
                  err_next = 1'b1;
                end else begin
                  bal_next[idx_reg] = sum[15:0];
                  done_next         = 1'b1;
                end
              end
              3'd2: begin
                if (amount <= cur_bal) begin
                  bal_next[idx_reg] = cur_bal - amount;
                  done_next         = 1'b1;
                end else begin
                  err_next = 1'b1;
                end
              end
              3'd3: done_next = 1'b1;
              default: begin
                done_next    = 1'b1;
                card_ok_next = 1'b0;
                auth_ok_next = 1'b0;
                state_next   = S_CARD;
              end
            endcase
          end
        end

        S_LOCKED: state_next = S_LOCKED;

        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      idx_reg      <= 2'd0;
      attempts_reg <= 2'd0;
      lock_reg     <= 4'd0;
      bal_reg      <= BAL_INIT;
      card_ok_reg  <= 1'b0;
      auth_ok_reg  <= 1'b0;
      locked_reg   <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      pin_prev_reg <= '0;
      txn_prev_reg <= '0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      attempts_reg <= attempts_next;
      lock_reg     <= lock_next;
      bal_reg      <= bal_next;
      card_ok_reg  <= card_ok_next;
      auth_ok_reg  <= auth_ok_next;
      locked_reg   <= locked_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      pin_prev_reg <= pin;
      txn_prev_reg <= transaction;
    end
  end

  assign state    = state_reg;
  assign balance  = card_ok_reg ? bal_reg[idx_reg] : 16'd0;
  assign card_ok  = card_ok_reg;
  assign auth_ok  = auth_ok_reg;
  assign locked   = locked_reg;
  assign txn_done = done_reg;
  assign txn_err  = err_reg;

endmodule

// File: tb/tb_atm_main.sv
// tb_atm_main -- directed scenarios followed by randomized traffic, every
// cycle compared against a behavioural ATM model kept in this bench.

module tb_atm_main;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] cardnumber;
  logic [19:0] pin;
  logic [15:0] amount;
  logic [2:0]  transaction;
  logic [15:0] balance;
  logic [2:0]  state;
  logic        card_ok, auth_ok, locked, txn_done, txn_err;

  atm_main dut (
    .clk(clk), .rst(rst), .start(start), .cardnumber(cardnumber), .pin(pin),
    .amount(amount), .transaction(transaction), .balance(balance), .state(state),
    .card_ok(card_ok), .auth_ok(auth_ok), .locked(locked),
    .txn_done(txn_done), .txn_err(txn_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int cards[4]    = '{11112222, 22223333, 33334444, 44445555};
  int pins[4]     = '{5432, 1234, 4321, 9999};
  int init_bal[4] = '{1000, 2500, 500, 0};

  int m_bal[4];
  bit m_lockbit[4];
  int m_phase;      // 0 idle, 1 waiting card, 2 waiting pin, 3 menu, 4 locked
  int m_acct;       // accepted account, -1 when none
  bit m_auth, m_locked, m_done, m_err;
  int m_misses;
  int m_pin_prev, m_txn_prev;

  function automatic int find_card(int c);
    for (int i = 0; i < 4; i++) if (cards[i] == c) return i;
    return -1;
  endfunction

  task automatic model_step();
    int p, t, a, k;
    bit new_pin, new_txn;
    m_done = 0; m_err = 0;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin m_bal[i] = init_bal[i]; m_lockbit[i] = 0; end
      m_phase = 0; m_acct = -1; m_auth = 0; m_locked = 0; m_misses = 0;
      m_pin_prev = 0; m_txn_prev = 0;
      return;
    end
    p = int'(pin); t = int'(transaction); a = int'(amount);
    new_pin = (p != 0) && (p != m_pin_prev);
    new_txn = (t >= 1) && (t <= 4) && (t != m_txn_prev);
    if (!start) begin
      m_phase = 0; m_acct = -1; m_auth = 0; m_locked = 0; m_misses = 0;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      k = find_card(int'(cardnumber));
      m_locked = 0;
      if (k >= 0 && m_lockbit[k]) m_locked = 1;
      else if (k >= 0) begin m_phase = 2; m_acct = k; m_misses = 0; end
    end else if (m_phase == 2 && new_pin) begin
      if (p == pins[m_acct]) begin
        m_phase = 3; m_auth = 1; m_misses = 0;
      end else begin
        m_err = 1;
        m_misses++;
`ifdef ATM_LOCKOUT_EN
        if (m_misses == 3) begin
          m_lockbit[m_acct] = 1; m_phase = 4; m_locked = 1; m_acct = -1; m_misses = 0;
        end
`else
        if (m_misses > 3) m_misses = 3;
`endif
      end
    end else if (m_phase == 3 && new_txn) begin
      if (t == 1) begin
        if (m_bal[m_acct] + a > 65535) m_err = 1;
        else begin m_bal[m_acct] += a; m_done = 1; end
      end else if (t == 2) begin
        if (a <= m_bal[m_acct]) begin m_bal[m_acct] -= a; m_done = 1; end
        else m_err = 1;
      end else if (t == 3) begin
        m_done = 1;
      end else begin
        m_done = 1; m_acct = -1; m_auth = 0; m_phase = 1;
      end
    end
    m_pin_prev = p; m_txn_prev = t;
  endtask

  // One clock: model consumes the inputs seen at the edge, then compare.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("state",    int'(state),    m_phase);
    chk("balance",  int'(balance),  (m_acct >= 0) ? m_bal[m_acct] : 0);
    chk("card_ok",  int'(card_ok),  int'(m_acct >= 0));
    chk("auth_ok",  int'(auth_ok),  int'(m_auth));
    chk("locked",   int'(locked),   int'(m_locked));
    chk("txn_done", int'(txn_done), int'(m_done));
    chk("txn_err",  int'(txn_err),  int'(m_err));
  endtask

  task automatic login(input int c, input int p);
    cardnumber = c; tick();
    pin = p; tick();
    cardnumber = 0;
  endtask

  initial begin
    int r;
    rst = 1; start = 0; cardnumber = 0; pin = 0; amount = 0; transaction = 0;
    tick(); tick();
    chk("rst_state", int'(state), 0);
    chk("rst_balance", int'(balance), 0);

    // Card acceptance and PIN retries
    rst = 0; start = 1; tick();
    chk("to_card", int'(state), 1);
    cardnumber = 11112222; tick();
    chk("to_pin", int'(state), 2);
    chk("bal_1000", int'(balance), 1000);
    cardnumber = 0;
    pin = 1111; tick(); chk("err1", int'(txn_err), 1);
    pin = 1112; tick(); chk("err2", int'(txn_err), 1);
    pin = 5432; tick(); chk("auth", int'(auth_ok), 1); chk("menu", int'(state), 3);

    // Deposit, withdraw, enquiry, exit
    amount = 500; transaction = 1; tick(); chk("dep_bal", int'(balance), 1500); chk("dep_done", int'(txn_done), 1);
    amount = 300; transaction = 2; tick(); chk("wd_bal", int'(balance), 1200); chk("wd_done", int'(txn_done), 1);
    transaction = 3; tick(); chk("enq_bal", int'(balance), 1200);
    transaction = 4; tick(); chk("exit_state", int'(state), 1); chk("exit_auth", int'(auth_ok), 0);
    transaction = 0;

    // Zero-balance withdraw rejected
    login(44445555, 9999);
    amount = 1; transaction = 2; tick(); chk("wd0_err", int'(txn_err), 1); chk("wd0_bal", int'(balance), 0);
    transaction = 4; tick(); transaction = 0;

    // Deposit overflow, then abort mid-menu
    login(22223333, 1234);
    amount = 65000; transaction = 1; tick(); chk("ovf_err", int'(txn_err), 1); chk("ovf_bal", int'(balance), 2500);
    start = 0; tick(); chk("abort_idle", int'(state), 0);
    transaction = 0; start = 1; tick();

`ifdef ATM_LOCKOUT_EN
    cardnumber = 22223333; tick();
    pin = 1; tick(); pin = 2; tick(); pin = 3; tick();
    chk("lock_flag", int'(locked), 1); chk("lock_state", int'(state), 4);
    start = 0; tick(); chk("unlock_idle", int'(state), 0);
    start = 1; tick(); tick(); chk("relock_card", int'(state), 1); chk("relock_flag", int'(locked), 1);
    cardnumber = 0; tick();
`else
    cardnumber = 33334444; tick(); cardnumber = 0;
    pin = 1; tick(); pin = 2; tick(); pin = 3; tick(); pin = 5; tick();
    chk("nolock_state", int'(state), 2); chk("nolock_flag", int'(locked), 0);
    pin = 4321; tick(); chk("late_auth", int'(auth_ok), 1);
    transaction = 4; tick(); transaction = 0;
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 499) == 0);
      start = ($urandom_range(0, 99) >= 3);
      r = $urandom_range(0, 9);
      cardnumber = (r < 3) ? cards[$urandom_range(0, 3)] : $urandom();
      r = $urandom_range(0, 9);
      if (r < 3) pin = 0;
      else if (r < 5) pin = pin;
      else if (r < 8) pin = 20'(pins[$urandom_range(0, 3)]);
      else pin = 20'($urandom_range(1, 9998));
      r = $urandom_range(0, 3);
      amount = (r == 0) ? 16'($urandom()) : 16'($urandom_range(0, 2000));
      transaction = ($urandom_range(0, 2) == 0) ? transaction : 3'($urandom_range(0, 7));
      tick();
      chk("exclusive", int'(txn_done && txn_err), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
